// File: rtl/hicore_skid_buf_pkg.sv
// Shared handshake encodings for skid buffers and future pipe/fifo variants.
// State code is {skid_vld, main_vld}; 2'b10 is unreachable.
package hicore_skid_buf_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b11;

endpackage

// File: rtl/hicore_dfflr.sv
// Generic load-enabled flop cell with synchronous active-high reset.
module hicore_dfflr #(
  parameter int               DW   = 1,
  parameter logic [DW-1:0]    RSTV = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (rst)       qout <= RSTV;
    else if (lden) qout <= dnxt;
  end

endmodule

// File: rtl/hicore_skid_buf.sv
// Reverse register slice: registered i_rdy, main + skid entries, per-entry cancel tag.
// state | meaning: EMPTY no entry, ONE main only, TWO main + skid (i_rdy low).
module hicore_skid_buf
  import hicore_skid_buf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  input  logic          i_cancel,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic          o_cancel,
  input  logic          branch,
  input  logic          flush
);

  logic          main_vld, skid_vld;
  logic          main_vld_n, skid_vld_n;
  logic [DW-1:0] main_dat, skid_dat, main_dat_n;
  logic          main_cancel, skid_cancel;
  logic          main_cancel_n, skid_cancel_n;
  logic          main_ld, skid_ld, main_from_skid;
  logic          rdy_q;
  logic          accept, take;
  logic [1:0]    state;

  assign state  = {skid_vld, main_vld};
  assign accept = i_vld & rdy_q;
  assign take   = main_vld & o_rdy;

  always_comb begin
    main_vld_n     = main_vld;
    skid_vld_n     = skid_vld;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_vld_n = 1'b1;
          main_ld    = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          main_ld = 1'b1;
        end else if (accept) begin
          skid_vld_n = 1'b1;
          skid_ld    = 1'b1;
        end else if (take) begin
          main_vld_n = 1'b0;
        end
      end
      ST_TWO: begin
        if (take) begin
          skid_vld_n     = 1'b0;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        main_vld_n = 1'b0;
        skid_vld_n = 1'b0;
      end
    endcase
    // flush wins: upstream/downstream handshakes still complete, nothing is kept
    if (flush) begin
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
      main_ld    = 1'b0;
      skid_ld    = 1'b0;
    end
  end

  assign main_dat_n = main_from_skid ? skid_dat : i_dat;

  always_comb begin
    main_cancel_n = main_cancel;
    skid_cancel_n = skid_cancel;
    if (flush) begin
      main_cancel_n = 1'b0;
      skid_cancel_n = 1'b0;
    end else begin
      if (main_ld)       main_cancel_n = (main_from_skid ? skid_cancel : i_cancel) | branch;
      else if (main_vld) main_cancel_n = main_cancel | branch;
      if (skid_ld)       skid_cancel_n = i_cancel | branch;
      else if (skid_vld) skid_cancel_n = skid_cancel | branch;
    end
  end

  hicore_dfflr #(.DW(1))  u_main_vld (.clk(clk), .rst(rst), .lden(1'b1), .dnxt(main_vld_n), .qout(main_vld));
  hicore_dfflr #(.DW(1))  u_skid_vld (.clk(clk), .rst(rst), .lden(1'b1), .dnxt(skid_vld_n), .qout(skid_vld));
  hicore_dfflr #(.DW(DW)) u_main_dat (.clk(clk), .rst(rst), .lden(main_ld), .dnxt(main_dat_n), .qout(main_dat));
  hicore_dfflr #(.DW(DW)) u_skid_dat (.clk(clk), .rst(rst), .lden(skid_ld), .dnxt(i_dat), .qout(skid_dat));
  hicore_dfflr #(.DW(1))  u_main_cnc (.clk(clk), .rst(rst), .lden(1'b1), .dnxt(main_cancel_n), .qout(main_cancel));
  hicore_dfflr #(.DW(1))  u_skid_cnc (.clk(clk), .rst(rst), .lden(1'b1), .dnxt(skid_cancel_n), .qout(skid_cancel));

  // Dedicated ready flop so i_rdy is a pure flop output, not an inverter off skid_vld.
  hicore_dfflr #(.DW(1), .RSTV(1'b1)) u_rdy (.clk(clk), .rst(rst), .lden(1'b1), .dnxt(~skid_vld_n), .qout(rdy_q));

  assign i_rdy    = rdy_q;
  assign o_vld    = main_vld;
  assign o_dat    = main_dat;
  assign o_cancel = main_cancel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (state != 2'b10);
      assert (rdy_q == ~skid_vld);
    end
  end

endmodule

// File: tb/tb_hicore_skid_buf.sv
// Directed bench for hicore_skid_buf plus a short randomized queue-model run.
module tb_hicore_skid_buf;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, i_vld, i_rdy, i_cancel, o_vld, o_rdy, o_cancel, branch, flush;
  logic [DW-1:0] i_dat, o_dat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] dat;
    logic          c;
  } ent_t;
  ent_t q[$];

  hicore_skid_buf #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat), .i_cancel(i_cancel),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_cancel(o_cancel),
    .branch(branch), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [DW-1:0] d, input logic c,
                     input logic r, input logic b, input logic f);
    i_vld = v; i_dat = d; i_cancel = c; o_rdy = r; branch = b; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic out3(input string tag, input logic v, input logic [DW-1:0] d, input logic rdy);
    chk({tag, "_vld"}, {31'd0, o_vld}, {31'd0, v});
    if (v) chk({tag, "_dat"}, o_dat, d);
    chk({tag, "_rdy"}, {31'd0, i_rdy}, {31'd0, rdy});
  endtask

  initial begin
    logic tk, ac;
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_vld", {31'd0, o_vld}, 0);
    chk("rst_dat", o_dat, 0);
    chk("rst_cnc", {31'd0, o_cancel}, 0);
    chk("rst_rdy", {31'd0, i_rdy}, 1);
    rst = 1'b0;

    // streaming
    for (int k = 1; k <= 8; k++) begin
      drv(1, k, 0, 1, 0, 0);
      tick();
      out3("stream", 1, k, 1);
    end
    drv(0, 0, 0, 1, 0, 0);
    tick();
    out3("stream_end", 0, 0, 1);

    // backpressure
    drv(1, 32'hA, 0, 0, 0, 0); tick(); out3("bp_a", 1, 32'hA, 1);
    drv(1, 32'hB, 0, 0, 0, 0); tick(); out3("bp_two", 1, 32'hA, 0);
    drv(0, 0, 0, 0, 0, 0);     tick(); out3("bp_hold", 1, 32'hA, 0);
    drv(0, 0, 0, 1, 0, 0);     tick(); out3("bp_b", 1, 32'hB, 1);
    tick();                            out3("bp_empty", 0, 0, 1);

    // branch marks both held entries
    drv(1, 32'h10, 0, 0, 0, 0); tick();
    drv(1, 32'h11, 0, 0, 0, 0); tick(); out3("br_two", 1, 32'h10, 0);
    chk("br_pre_cnc", {31'd0, o_cancel}, 0);
    drv(0, 0, 0, 0, 1, 0);      tick();
    out3("br_main", 1, 32'h10, 0);
    chk("br_main_cnc", {31'd0, o_cancel}, 1);
    drv(0, 0, 0, 1, 0, 0);      tick();
    out3("br_skid", 1, 32'h11, 1);
    chk("br_skid_cnc", {31'd0, o_cancel}, 1);
    drv(1, 32'h12, 0, 1, 0, 0); tick();
    out3("br_new", 1, 32'h12, 1);
    chk("br_new_cnc", {31'd0, o_cancel}, 0);
    drv(0, 0, 0, 1, 0, 0);      tick();
    out3("br_empty", 0, 0, 1);

    // flush with concurrent take
    drv(1, 32'h20, 0, 0, 0, 0); tick();
    drv(1, 32'h21, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 1, 0);      tick();
    chk("fl_cnc_set", {31'd0, o_cancel}, 1);
    out3("fl_two", 1, 32'h20, 0);
    drv(1, 32'h22, 0, 1, 1, 1); tick();
    out3("fl_after", 0, 0, 1);
    chk("fl_cnc_clr", {31'd0, o_cancel}, 0);
    drv(0, 0, 0, 1, 0, 0);      tick();
    out3("fl_no21", 0, 0, 1);
    // flush swallows an accept made in the same cycle
    drv(1, 32'h23, 0, 0, 0, 0); tick(); out3("fl_one", 1, 32'h23, 1);
    drv(1, 32'h24, 1, 0, 0, 1); tick(); out3("fl_drop", 0, 0, 1);
    drv(1, 32'h25, 0, 1, 0, 0); tick(); out3("fl_next", 1, 32'h25, 1);
    chk("fl_next_cnc", {31'd0, o_cancel}, 0);
    drv(0, 0, 0, 1, 0, 0);      tick(); out3("fl_empty", 0, 0, 1);

    // reset in TWO
    drv(1, 32'h40, 1, 0, 0, 0); tick();
    drv(1, 32'h41, 0, 0, 0, 0); tick(); out3("rs_two", 1, 32'h40, 0);
    drv(0, 0, 0, 0, 0, 0); rst = 1'b1; tick(); rst = 1'b0;
    out3("rs_clr", 0, 0, 1);
    chk("rs_dat", o_dat, 0);
    chk("rs_cnc", {31'd0, o_cancel}, 0);
    drv(1, 32'h30, 0, 0, 0, 0); tick(); out3("rs_acc", 1, 32'h30, 1);
    drv(0, 0, 0, 1, 0, 0);      tick(); out3("rs_empty", 0, 0, 1);

    // randomized run against a two-deep queue model
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(9) < 7), $urandom, ($urandom_range(4) == 0),
          ($urandom_range(9) < 6), ($urandom_range(9) == 0), ($urandom_range(39) == 0));
      tk = (q.size() > 0) && o_rdy;
      ac = i_vld && (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (branch) foreach (q[i]) q[i].c = 1'b1;
        if (tk) void'(q.pop_front());
        if (ac) q.push_back('{dat: i_dat, c: i_cancel | branch});
      end
      tick();
      chk("rnd_vld", {31'd0, o_vld}, {31'd0, (q.size() > 0)});
      chk("rnd_rdy", {31'd0, i_rdy}, {31'd0, (q.size() < 2)});
      if (q.size() > 0) begin
        chk("rnd_dat", o_dat, q[0].dat);
        chk("rnd_cnc", {31'd0, o_cancel}, {31'd0, q[0].c});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
